// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with level, thresholds and registered read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module param_sync_fifo #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 rd_en,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam int ADDRW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int LVLW  = $clog2(DEPTH + 1);

    localparam logic [LVLW-1:0]  DEPTH_L = LVLW'(DEPTH);
    localparam logic [LVLW-1:0]  AF_L    = LVLW'(AF_THRESH);
    localparam logic [LVLW-1:0]  AE_L    = LVLW'(AE_THRESH);
    localparam logic [ADDRW-1:0] LAST    = ADDRW'(DEPTH - 1);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRW-1:0]     wr_ptr;
    logic [ADDRW-1:0]     rd_ptr;
    logic [LVLW-1:0]      level_nxt;
    logic                 wr_acc;
    logic                 rd_acc;

    // Explicit wrap so non-power-of-two depths stay in range
    function automatic logic [ADDRW-1:0] ptr_inc(input logic [ADDRW-1:0] p);
        return (p == LAST) ? '0 : p + ADDRW'(1);
    endfunction

    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    assign wr_acc = rstn & wr_en & ~full;
    assign rd_acc = rstn & rd_en & ~empty;

    always_comb begin
        level_nxt = level;
        unique case (1'b1)
            (wr_acc & ~rd_acc): level_nxt = level + LVLW'(1);
            (rd_acc & ~wr_acc): level_nxt = level - LVLW'(1);
            default:            level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;
            level    <= level_nxt;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a DEPTH=16 and a DEPTH=5 instance.
// Error-flag checks build only with SYNC_FIFO_ERR_FLAGS_EN.
module tb_param_sync_fifo;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;

    logic       w16 = 1'b0, r16 = 1'b0;
    logic [7:0] d16 = 8'h00;
    logic       f16, af16, e16, ae16, rv16;
    logic [7:0] q16;
    logic [4:0] l16;

    logic       w5 = 1'b0, r5 = 1'b0;
    logic [7:0] d5 = 8'h00;
    logic       f5, af5, e5, ae5, rv5;
    logic [7:0] q5;
    logic [2:0] l5;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ov16, un16, ov5, un5;
`endif

    always #5 clk = ~clk;

    param_sync_fifo u16 (
        .clk(clk), .rstn(rstn),
        .wr_en(w16), .wr_data(d16), .full(f16), .almost_full(af16),
        .rd_en(r16), .rd_data(q16), .rd_valid(rv16),
        .empty(e16), .almost_empty(ae16), .level(l16)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(ov16), .underflow(un16)
`endif
    );

    param_sync_fifo #(.DATAWIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u5 (
        .clk(clk), .rstn(rstn),
        .wr_en(w5), .wr_data(d5), .full(f5), .almost_full(af5),
        .rd_en(r5), .rd_data(q5), .rd_valid(rv5),
        .empty(e5), .almost_empty(ae5), .level(l5)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(ov5), .underflow(un5)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         lvl;
        logic       rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string t, input int lvl, input logic rv, input logic [7:0] rd);
        chk({t, ".level"}, 32'(l16), lvl);
        chk({t, ".full"}, 32'(f16), 32'(lvl == 16));
        chk({t, ".empty"}, 32'(e16), 32'(lvl == 0));
        chk({t, ".afull"}, 32'(af16), 32'(lvl >= 14));
        chk({t, ".aempty"}, 32'(ae16), 32'(lvl <= 2));
        chk({t, ".rd_valid"}, 32'(rv16), 32'(rv));
        chk({t, ".rd_data"}, 32'(q16), 32'(rd));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] q5m[$];
        logic [7:0] mrd;
        int mlvl, wcnt, rcnt, saw_full;
        logic wacc, racc;

        tbl[0]  = '{1'b1, 1'b1, 8'hA1, 1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hA1};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hA1};
        tbl[3]  = '{1'b1, 1'b0, 8'hB1, 1, 1'b0, 8'hA1};
        tbl[4]  = '{1'b1, 1'b0, 8'hB2, 2, 1'b0, 8'hA1};
        tbl[5]  = '{1'b1, 1'b0, 8'hB3, 3, 1'b0, 8'hA1};
        tbl[6]  = '{1'b1, 1'b1, 8'hB4, 3, 1'b1, 8'hB1};
        tbl[7]  = '{1'b1, 1'b1, 8'hB5, 3, 1'b1, 8'hB2};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 3, 1'b0, 8'hB2};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'hB3};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hB4};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hB5};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hB5};

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk16("reset", 0, 1'b0, 8'h00);
        chk("d5_reset.empty", 32'(e5), 1);
        chk("d5_reset.level", 32'(l5), 0);
        rstn = 1'b1;

        // Fill to full, then one dropped write
        for (int i = 1; i <= 16; i++) begin
            w16 = 1'b1;
            d16 = 8'(i);
            tick();
            chk16($sformatf("fill%0d", i), i, 1'b0, 8'h00);
        end
        d16 = 8'hFF;
        tick();
        chk16("fill_drop", 16, 1'b0, 8'h00);
        w16 = 1'b0;

        // Drain in order, then one rejected read
        r16 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk16($sformatf("drain%0d", i), 16 - i, 1'b1, 8'(i));
        end
        tick();
        chk16("drain_under", 0, 1'b0, 8'h10);
        r16 = 1'b0;

        // Vector table from a fresh reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            w16 = tbl[i].w;
            r16 = tbl[i].r;
            d16 = tbl[i].d;
            tick();
            chk16($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].rv, tbl[i].rd);
        end
        w16 = 1'b0;
        r16 = 1'b0;

        // Concurrent traffic at level 5
        for (int i = 0; i < 5; i++) begin
            w16 = 1'b1;
            d16 = 8'h20 + 8'(i);
            tick();
            q.push_back(d16);
        end
        r16 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d16 = 8'h30 + 8'(k);
            tick();
            exp = q.pop_front();
            q.push_back(d16);
            chk16($sformatf("conc5_%0d", k), 5, 1'b1, exp);
        end
        r16 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            d16 = 8'h40 + 8'(k);
            tick();
            q.push_back(d16);
            chk16($sformatf("refill%0d", k), 6 + k, 1'b0, exp);
        end

        // Concurrent at full: read wins, write dropped
        d16 = 8'hEE;
        r16 = 1'b1;
        tick();
        exp = q.pop_front();
        chk16("conc_full", 15, 1'b1, exp);
        w16 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp = q.pop_front();
            chk16($sformatf("drain_b%0d", i), 14 - i, 1'b1, exp);
        end

        // Concurrent at empty: write wins, no bypass
        w16 = 1'b1;
        d16 = 8'h77;
        tick();
        chk16("conc_empty", 1, 1'b0, exp);
        w16 = 1'b0;
        tick();
        chk16("conc_empty_rd", 0, 1'b1, 8'h77);
        r16 = 1'b0;

        // Reset mid-operation; requests during reset ignored
        w16 = 1'b1;
        d16 = 8'h55;
        tick();
        tick();
        chk16("pre_reset", 2, 1'b0, 8'h77);
        rstn = 1'b0;
        r16 = 1'b1;
        tick();
        chk16("mid_reset", 0, 1'b0, 8'h00);
        tick();
        chk16("in_reset", 0, 1'b0, 8'h00);
        w16 = 1'b0;
        r16 = 1'b0;
        rstn = 1'b1;
        tick();
        chk16("post_reset", 0, 1'b0, 8'h00);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("err_init.ov", 32'(ov16), 0);
        chk("err_init.un", 32'(un16), 0);
        r16 = 1'b1;
        tick();
        r16 = 1'b0;
        chk("err_under.un", 32'(un16), 1);
        chk("err_under.ov", 32'(ov16), 0);
        w16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d16 = 8'(i);
            tick();
        end
        chk("err_full.ov", 32'(ov16), 0);
        tick();
        w16 = 1'b0;
        chk("err_over.ov", 32'(ov16), 1);
        r16 = 1'b1;
        tick();
        r16 = 1'b0;
        w16 = 1'b1;
        tick();
        w16 = 1'b0;
        tick();
        chk("err_sticky.ov", 32'(ov16), 1);
        chk("err_sticky.un", 32'(un16), 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("err_clr.ov", 32'(ov16), 0);
        chk("err_clr.un", 32'(un16), 0);
        chk16("err_clr", 0, 1'b0, 8'h00);
`endif

        // DEPTH=5 wrap test with a queue scoreboard
        mlvl = 0;
        wcnt = 0;
        rcnt = 0;
        saw_full = 0;
        mrd = 8'h00;
        for (int cyc = 0; cyc < 100; cyc++) begin
            w5 = (wcnt < 23) && ((cyc % 4) != 3);
            r5 = ((cyc % 3) == 0) || (wcnt >= 23);
            d5 = 8'h80 + 8'(wcnt);
            wacc = w5 && (mlvl < 5);
            racc = r5 && (mlvl > 0);
            tick();
            if (racc) begin
                mrd = q5m.pop_front();
                rcnt++;
            end
            if (wacc) begin
                q5m.push_back(d5);
                wcnt++;
            end
            mlvl = mlvl + int'(wacc) - int'(racc);
            if (mlvl == 5) saw_full = 1;
            chk($sformatf("d5_%0d.level", cyc), 32'(l5), mlvl);
            chk($sformatf("d5_%0d.full", cyc), 32'(f5), 32'(mlvl == 5));
            chk($sformatf("d5_%0d.empty", cyc), 32'(e5), 32'(mlvl == 0));
            chk($sformatf("d5_%0d.afull", cyc), 32'(af5), 32'(mlvl >= 4));
            chk($sformatf("d5_%0d.aempty", cyc), 32'(ae5), 32'(mlvl <= 1));
            chk($sformatf("d5_%0d.rd_valid", cyc), 32'(rv5), 32'(racc));
            chk($sformatf("d5_%0d.rd_data", cyc), 32'(q5), 32'(mrd));
        end
        w5 = 1'b0;
        r5 = 1'b0;
        chk("d5_reads", rcnt, 23);
        chk("d5_saw_full", saw_full, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
